spike_winner_decoder: RTL and testbench

Sits directly downstream of the winner-take-all column and turns its per-line output spike pulses into one decoded record per gamma cycle. Each record holds the winning line index, its spike time within the gamma cycle, a no-spike flag and a multi-spike flag. Records are buffered in a small FIFO and delivered over a valid/ready stream to the readout or learning logic.

---
 rtl/spike_decoder_pkg.sv | 33 +++
 rtl/spike_winner_decoder_if.sv | 22 ++
 rtl/decoder_fifo.sv | 58 +++++
 rtl/spike_winner_decoder.sv | 147 ++++++++++++++
 tb/tb_spike_winner_decoder.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spike_decoder_pkg.sv
// Shared types, constants and bit-scan helpers for the spike winner decoder.
package spike_decoder_pkg;

    localparam int DROP_CNT_W = 8;

    // Helpers scan a fixed maximum width; callers zero-extend their
    // NUM_INPUTS-bit vector, and the unused upper bits fold away.
    localparam int MAX_INPUTS = 64;

    typedef enum logic {
        IDLE     = 1'b0,
        CAPTURED = 1'b1
    } acc_state_e;

    function automatic int lowest_set_idx(input logic [MAX_INPUTS-1:0] v);
        int idx;
        idx = 0;
        for (int i = MAX_INPUTS - 1; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

    function automatic int popcount(input logic [MAX_INPUTS-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < MAX_INPUTS; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/spike_winner_decoder_if.sv
// Decoded-record valid/ready stream between the decoder and its consumer.
interface spike_winner_decoder_if #(
    parameter int IDX_W  = 4,
    parameter int TIME_W = 4
) ();
    logic              result_valid;
    logic              result_ready;
    logic [IDX_W-1:0]  result_winner;
    logic [TIME_W-1:0] result_time;
    logic              result_none;
    logic              result_multi;

    modport master (
        output result_valid, result_winner, result_time, result_none, result_multi,
        input  result_ready
    );

    modport slave (
        input  result_valid, result_winner, result_time, result_none, result_multi,
        output result_ready
    );
endinterface

// File: rtl/decoder_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module decoder_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             aclk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]                 count_q, count_d;
    logic                        do_push, do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = mem_q[rd_ptr_q];
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);

    // Next-state for storage, pointers (wrap naturally, DEPTH is 2^n) and fill count
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
        else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
    end

    // State registers; storage is cleared so the data outputs read zero after reset
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/spike_winner_decoder.sv
// Turns WTA spike pulses into one winner record per gamma cycle, buffered in
// a small FIFO. Optional drop counter: define SPIKE_DECODER_DROP_CNT_EN.
module spike_winner_decoder
    import spike_decoder_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int NUM_INPUTS        = 16,
    parameter int FIFO_DEPTH        = 4,
    localparam int IDX_W            = $clog2(NUM_INPUTS),
    localparam int TIME_W           = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                  aclk,
    input  logic                  rst,
    input  logic [NUM_INPUTS-1:0] wta_spikes,
    output logic                  gamma_start,
    spike_winner_decoder_if.master res
`ifdef SPIKE_DECODER_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_count
`endif
);
    if (PULSE_WIDTH >= GAMMA_CYCLE_WIDTH) begin : g_chk_pulse
        $error("PULSE_WIDTH must be smaller than GAMMA_CYCLE_WIDTH");
    end
    if (NUM_INPUTS < 2 || NUM_INPUTS > MAX_INPUTS) begin : g_chk_inputs
        $error("NUM_INPUTS out of range");
    end
    if (GAMMA_CYCLE_WIDTH < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_geom
        $error("bad GAMMA_CYCLE_WIDTH or FIFO_DEPTH");
    end

    typedef struct packed {
        logic              none;
        logic              multi;
        logic [TIME_W-1:0] t;
        logic [IDX_W-1:0]  winner;
    } rec_t;

    logic [TIME_W-1:0]     gamma_cnt_q, gamma_cnt_d;
    logic [NUM_INPUTS-1:0] prev_q, rise;
    acc_state_e            state_q, state_d, cur_state;
    logic [IDX_W-1:0]      winner_q, winner_d, cur_winner;
    logic [TIME_W-1:0]     time_q, time_d, cur_time;
    logic                  multi_q, multi_d, cur_multi;
    logic                  commit, push, pop, fifo_full, fifo_empty;
    rec_t                  commit_rec, head_rec;

    assign rise        = wta_spikes & ~prev_q;
    assign gamma_start = (gamma_cnt_q == '0);
    assign pop         = res.result_valid & res.result_ready;
    assign push        = commit & (~fifo_full | pop);

    // Fold this cycle's rises into the accumulator, then commit/clear at the wrap
    always_comb begin
        cur_state  = state_q;
        cur_winner = winner_q;
        cur_time   = time_q;
        cur_multi  = multi_q;
        if (rise != '0) begin
            if (state_q == IDLE) begin
                cur_state  = CAPTURED;
                cur_winner = IDX_W'(lowest_set_idx(MAX_INPUTS'(rise)));
                cur_time   = gamma_cnt_q;
                cur_multi  = (popcount(MAX_INPUTS'(rise)) > 1);
            end else begin
                cur_multi  = 1'b1;
            end
        end

        commit      = (gamma_cnt_q == TIME_W'(GAMMA_CYCLE_WIDTH - 1));
        gamma_cnt_d = commit ? '0 : gamma_cnt_q + TIME_W'(1);

        commit_rec      = '0;
        commit_rec.none = (cur_state == IDLE);
        if (cur_state == CAPTURED) begin
            commit_rec.winner = cur_winner;
            commit_rec.t      = cur_time;
            commit_rec.multi  = cur_multi;
        end

        state_d  = cur_state;
        winner_d = cur_winner;
        time_d   = cur_time;
        multi_d  = cur_multi;
        if (commit) begin
            state_d  = IDLE;
            winner_d = '0;
            time_d   = '0;
            multi_d  = 1'b0;
        end
    end

    // Counter, edge-detect history and accumulator registers
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            gamma_cnt_q <= '0;
            prev_q      <= '0;
            state_q     <= IDLE;
            winner_q    <= '0;
            time_q      <= '0;
            multi_q     <= 1'b0;
        end else begin
            gamma_cnt_q <= gamma_cnt_d;
            prev_q      <= wta_spikes;
            state_q     <= state_d;
            winner_q    <= winner_d;
            time_q      <= time_d;
            multi_q     <= multi_d;
        end
    end

    decoder_fifo #(.WIDTH($bits(rec_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .aclk      (aclk),
        .rst       (rst),
        .push      (push),
        .push_data (commit_rec),
        .full      (fifo_full),
        .pop       (pop),
        .pop_data  (head_rec),
        .empty     (fifo_empty)
    );

    assign res.result_valid  = ~fifo_empty;
    assign res.result_winner = head_rec.winner;
    assign res.result_time   = head_rec.t;
    assign res.result_none   = head_rec.none;
    assign res.result_multi  = head_rec.multi;

`ifdef SPIKE_DECODER_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Count commits that found the FIFO full with nothing leaving; saturate
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (commit && !push && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end

    // Drop counter register
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) drop_cnt_q <= '0;
        else     drop_cnt_q <= drop_cnt_d;
    end

    assign drop_count = drop_cnt_q;
`endif
endmodule

// File: tb/tb_spike_winner_decoder.sv
// Directed + randomized bench for spike_winner_decoder with an event-list model.
module tb_spike_winner_decoder;
    import spike_decoder_pkg::*;

    localparam int GCW = 16;
    localparam int NI  = 16;
    localparam int FD  = 4;

    logic          aclk = 1'b0;
    logic          rst;
    logic [NI-1:0] wta_spikes;
    logic          gamma_start;
`ifdef SPIKE_DECODER_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_count;
`endif

    spike_winner_decoder_if #(.IDX_W(4), .TIME_W(4)) res ();

    spike_winner_decoder #(
        .GAMMA_CYCLE_WIDTH (GCW),
        .PULSE_WIDTH       (8),
        .NUM_INPUTS        (NI),
        .FIFO_DEPTH        (FD)
    ) dut (
        .aclk        (aclk),
        .rst         (rst),
        .wta_spikes  (wta_spikes),
        .gamma_start (gamma_start),
        .res         (res)
`ifdef SPIKE_DECODER_DROP_CNT_EN
        ,
        .drop_count  (drop_count)
`endif
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [3:0] w;
        logic [3:0] t;
        logic       none;
        logic       multi;
    } rec_t;

    // Reference model: list of rising-edge events in the current gamma cycle,
    // and a bounded queue of committed records.
    rec_t          q[$];
    int            ev_idx[$];
    int            ev_t[$];
    int            m_cnt;
    int            m_drops;
    logic [NI-1:0] m_prev;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        ev_idx.delete();
        ev_t.delete();
        m_cnt   = 0;
        m_drops = 0;
        m_prev  = '0;
    endtask

    // One clock: drive inputs, check outputs at negedge, advance model at posedge.
    task automatic tick(input logic [NI-1:0] sp, input logic rdy);
        logic          pop;
        logic [NI-1:0] rise;
        rec_t          r;
        int            bi;
        wta_spikes       = sp;
        res.result_ready = rdy;
        @(negedge aclk);
        chk("gamma_start", 32'(gamma_start), 32'(m_cnt == 0));
        chk("valid", 32'(res.result_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("winner", 32'(res.result_winner), 32'(q[0].w));
            chk("time",   32'(res.result_time),   32'(q[0].t));
            chk("none",   32'(res.result_none),   32'(q[0].none));
            chk("multi",  32'(res.result_multi),  32'(q[0].multi));
        end
        pop = (q.size() != 0) && rdy;
        @(posedge aclk);
        rise = sp & ~m_prev;
        for (int i = 0; i < NI; i++) begin
            if (rise[i]) begin
                ev_idx.push_back(i);
                ev_t.push_back(m_cnt);
            end
        end
        m_prev = sp;
        if (pop) q.delete(0);
        if (m_cnt == GCW - 1) begin
            if (ev_idx.size() == 0) begin
                r = '{w: 4'd0, t: 4'd0, none: 1'b1, multi: 1'b0};
            end else begin
                bi = 0;
                for (int j = 1; j < ev_idx.size(); j++) begin
                    if (ev_t[j] < ev_t[bi] || (ev_t[j] == ev_t[bi] && ev_idx[j] < ev_idx[bi])) bi = j;
                end
                r = '{w: 4'(ev_idx[bi]), t: 4'(ev_t[bi]), none: 1'b0, multi: (ev_idx.size() > 1)};
            end
            if (q.size() < FD) q.push_back(r);
            else               m_drops++;
            ev_idx.delete();
            ev_t.delete();
        end
        m_cnt = (m_cnt + 1) % GCW;
        #1;
    endtask

    task automatic run_until(input int cnt, input logic [NI-1:0] sp, input logic rdy);
        int guard;
        guard = 0;
        while (m_cnt != cnt && guard < 2 * GCW) begin
            tick(sp, rdy);
            guard++;
        end
        if (m_cnt != cnt) chk("run_until_bound", 32'(m_cnt), 32'(cnt));
    endtask

    task automatic expect_head(input int w, input int t, input logic none, input logic multi);
        chk("head_valid", 32'(res.result_valid),  32'd1);
        chk("head_winner", 32'(res.result_winner), 32'(w));
        chk("head_time",  32'(res.result_time),   32'(t));
        chk("head_none",  32'(res.result_none),   32'(none));
        chk("head_multi", 32'(res.result_multi),  32'(multi));
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        #1;
        chk("rst_valid", 32'(res.result_valid),  32'd0);
        chk("rst_winner", 32'(res.result_winner), 32'd0);
        chk("rst_time",  32'(res.result_time),   32'd0);
        chk("rst_none",  32'(res.result_none),   32'd0);
        chk("rst_multi", 32'(res.result_multi),  32'd0);
        chk("rst_gamma_start", 32'(gamma_start), 32'd1);
`ifdef SPIKE_DECODER_DROP_CNT_EN
        chk("rst_drop_count", 32'(drop_count), 32'd0);
`endif
        repeat (cycles) @(posedge aclk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        res.result_ready = 1'b1;
        // line 3 already high during reset: counts as a rise at time 0
        wta_spikes = NI'(1) << 3;
        do_reset(3);
        repeat (4) tick(NI'(1) << 3, 1'b1);
        run_until(0, '0, 1'b1);
        expect_head(3, 0, 1'b0, 1'b0);

        // single spike on line 5 at cnt 3, visible for exactly one cycle
        run_until(3, '0, 1'b1);
        repeat (8) tick(NI'(1) << 5, 1'b1);
        run_until(0, '0, 1'b1);
        expect_head(5, 3, 1'b0, 1'b0);
        tick('0, 1'b1);
        chk("single_one_cycle", 32'(res.result_valid), 32'd0);

        // simultaneous lines 2 and 9 at cnt 7
        run_until(7, '0, 1'b1);
        repeat (4) tick((NI'(1) << 2) | (NI'(1) << 9), 1'b1);
        run_until(0, '0, 1'b1);
        expect_head(2, 7, 1'b0, 1'b1);

        // line 12 at cnt 1, late line 0 at cnt 10
        run_until(1, '0, 1'b1);
        repeat (3) tick(NI'(1) << 12, 1'b1);
        run_until(10, '0, 1'b1);
        repeat (3) tick(NI'(1), 1'b1);
        run_until(0, '0, 1'b1);
        expect_head(12, 1, 1'b0, 1'b1);

        // quiet gamma cycle
        repeat (GCW) tick('0, 1'b1);
        expect_head(0, 0, 1'b1, 1'b0);

        // pulse on line 4 rising at cnt 15 and continuing across the boundary
        run_until(15, '0, 1'b1);
        tick(NI'(1) << 4, 1'b1);
        expect_head(4, 15, 1'b0, 1'b0);
        repeat (7) tick(NI'(1) << 4, 1'b1);
        run_until(0, '0, 1'b1);
        expect_head(0, 0, 1'b1, 1'b0);

        // backpressure: 6 commits with ready low -> 4 kept, 2 dropped
        tick('0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            run_until(k + 2, '0, 1'b0);
            tick(NI'(1) << k, 1'b0);
            run_until(0, '0, 1'b0);
        end
        expect_head(0, 2, 1'b0, 1'b0);
`ifdef SPIKE_DECODER_DROP_CNT_EN
        chk("drop_count_two", 32'(drop_count), 32'd2);
`endif
        run_until(15, '0, 1'b1);
        chk("drained", 32'(res.result_valid), 32'd0);

        // refill to full, then pulse ready in the commit cycle: no drop
        tick('0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            run_until(k + 3, '0, 1'b0);
            tick(NI'(1) << (k + 8), 1'b0);
            run_until(0, '0, 1'b0);
        end
        run_until(5, '0, 1'b0);
        tick(NI'(1) << 13, 1'b0);
        run_until(15, '0, 1'b0);
        tick('0, 1'b1);
        expect_head(8, 3, 1'b0, 1'b0);
`ifdef SPIKE_DECODER_DROP_CNT_EN
        chk("drop_count_hold", 32'(drop_count), 32'd2);
`endif
        run_until(15, '0, 1'b1);
        tick('0, 1'b1);

        // reset mid-cycle after a capture: partial record discarded
        run_until(5, '0, 1'b1);
        repeat (2) tick(NI'(1) << 6, 1'b1);
        run_until(9, '0, 1'b1);
        wta_spikes = '0;
        do_reset(2);
        run_until(4, '0, 1'b1);
        repeat (2) tick(NI'(1) << 7, 1'b1);
        run_until(0, '0, 1'b1);
        expect_head(7, 4, 1'b0, 1'b0);

        // randomized sparse spikes with random backpressure
        repeat (40 * GCW) begin
            tick(NI'($urandom & $urandom & $urandom & $urandom), ($urandom_range(0, 3) != 0));
        end
`ifdef SPIKE_DECODER_DROP_CNT_EN
        chk("drop_count_rand", 32'(drop_count), 32'(m_drops));
`endif
        repeat (FD * GCW) tick('0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
